// File: rtl/piso_serializer_pkg.sv
// Shared types and constants for the PISO serializer.
package piso_pkg;

  // Word width that matches the 4-bit SISO shift register downstream.
  localparam int PISO_DEFAULT_WIDTH = 4;

  // PARITY is only reachable when the parity option is compiled in.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  // Bit counter width: wide enough to hold WIDTH so it never wraps in a frame.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame bit counter: cleared on load, incremented per shifted bit,
// flags the last data bit (count == WIDTH-1).
module piso_bit_counter
  import piso_pkg::*;
#(
  parameter int WIDTH = PISO_DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer feeding the SISO shift register's d input.
// Optional even-parity bit appended after the data when the macro
// PISO_SERIALIZER_PARITY_EN is defined.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = PISO_DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sdo_q, sdo_d;
  logic             sdo_valid_q, sdo_valid_d;
  logic             done_q, done_d;
  logic             cnt_clr, cnt_inc, cnt_tc;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             par_q, par_d;
`endif

  // Bit at the output end of a word.
  function automatic logic out_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  // Move a word one place toward the output end, zero filling behind.
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? (v << 1) : (v >> 1);
  endfunction

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .tc  (cnt_tc)
  );

  // Next-state and registered-output logic. The first bit is launched at the
  // load edge so sdo is already valid in the cycle after the handshake;
  // shreg therefore holds the bits still to be sent.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    sdo_d       = 1'b0;
    sdo_valid_d = 1'b0;
    done_d      = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          state_d     = SHIFT;
          shreg_d     = shift_out(din);
          sdo_d       = out_bit(din);
          sdo_valid_d = 1'b1;
          cnt_clr     = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
          par_d       = ^din;
`endif
        end
      end
      SHIFT: begin
        cnt_inc = 1'b1;
        shreg_d = shift_out(shreg_q);
        if (cnt_tc) begin
`ifdef PISO_SERIALIZER_PARITY_EN
          state_d     = PARITY;
          sdo_d       = par_q;
          sdo_valid_d = 1'b1;
`else
          state_d = IDLE;
          done_d  = 1'b1;
`endif
        end else begin
          sdo_d       = out_bit(shreg_q);
          sdo_valid_d = 1'b1;
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, shift register and output registers; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      sdo_q       <= 1'b0;
      sdo_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      sdo_q       <= sdo_d;
      sdo_valid_q <= sdo_valid_d;
      done_q      <= done_d;
    end
  end

`ifdef PISO_SERIALIZER_PARITY_EN
  // Parity of the word captured at the load edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign sdo        = sdo_q;
  assign sdo_valid  = sdo_valid_q;
  assign done       = done_q;
  assign load_ready = !rst && (state_q == IDLE);
  assign busy       = !rst && (state_q != IDLE);

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out serializer that feeds the 4-bit SISO shift register's serial `d` input. It accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock on `sdo`, qualified by `sdo_valid`. It signals frame completion with a one-cycle `done` pulse. The block sits directly upstream of SISO; `sdo` connects to SISO `d`, and both share `clk`.

## Interface
- `WIDTH`, default 4: data bits per word (≥2); default matches the 4-bit SISO.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `din` in WIDTH: parallel word to serialize.
- `load_valid` in 1: `din` is valid.
- `load_ready` out 1: block can accept a word.
- `sdo` out 1: serial data, connects to SISO `d`.
- `sdo_valid` out 1: `sdo` carries a frame bit this cycle.
- `busy` out 1: frame in progress (state ≠ IDLE).
- `done` out 1: one-cycle pulse after the final frame bit.

## Operation
- FSM states: IDLE, SHIFT, PARITY (only with the macro, see Configuration).
- IDLE:
  - `load_ready`=1.
  - If `load_valid`&&`load_ready` at an edge: capture `din` into `shreg`, set `bitcnt`=0, go to SHIFT.
  - Otherwise stay; `sdo_valid`=0 and `sdo` holds 0.
- SHIFT:
  - `sdo_valid`=1; `sdo` = `shreg[WIDTH-1]` if MSB_FIRST, else `shreg[0]`.
  - Each edge shifts `shreg` toward the output end (zero fill) and increments `bitcnt`.
  - When `bitcnt`==WIDTH-1 at an edge: go to PARITY if enabled, else to IDLE, and assert `done` for the next cycle.
- `load_ready`=0 outside IDLE.
  - A `load_valid` presented then is not accepted.
  - The source must hold `din`/`load_valid` until the handshake completes; no queuing.
- `bitcnt` width is $clog2(WIDTH+1); it never wraps within a frame.
- All outputs are registered except `load_ready` and `busy`, which decode the state and are forced 0 while `rst`=1.
- Reset (at any time, including mid-frame):
  - Next edge gives state=IDLE, `shreg`=0, `bitcnt`=0, `sdo`=0, `sdo_valid`=0, `done`=0.
  - An in-flight frame is aborted and no `done` is issued.
  - `load_valid` is ignored while `rst`=1.
- Simultaneous `rst` and `load_valid`: reset wins and the word is not captured.

## Timing
- Handshake edge E: data bit k appears on `sdo` in cycle E+1+k, for k=0..WIDTH-1.
- Without parity: `done`=1 and state=IDLE in cycle E+1+WIDTH. `load_ready`=1 in that same cycle, so the next handshake can occur at its closing edge.
- Throughput: one word per WIDTH+1 cycles (WIDTH+2 with parity).
- `sdo` changes only on `clk` rising edges, so downstream SISO samples each bit one edge after it is presented.
- `done` is never asserted in the same cycle as `sdo_valid`.

## Configuration
- Macro `PISO_SERIALIZER_PARITY_EN`.
- Defined:
  - The PARITY state is compiled in.
  - After the last data bit, one extra cycle drives `sdo` = even parity (XOR of the captured `din`) with `sdo_valid`=1.
  - `done` is then pulsed in the following cycle.
  - A parity register captured at the load edge is added.
- Undefined: no PARITY state and no parity register; frame length is exactly WIDTH.

## Structure
- Package `piso_pkg` holds:
  - the state typedef enum {IDLE, SHIFT, PARITY};
  - the localparam function for counter width;
  - the default WIDTH constant, 4.
- Sub-module `piso_bit_counter` (load-clear, increment, terminal-count flag at WIDTH-1). The top holds the FSM, `shreg` and output registers.

## Test plan
- WIDTH=4, MSB_FIRST=1, `din`=4'b1011 loaded at edge E → `sdo`=1,0,1,1 in cycles E+1..E+4 with `sdo_valid`=1; `done`=1 at E+5. A chained SISO shows `q`=4'b1011 after the 4th shift.
- MSB_FIRST=0, `din`=4'b1011 → `sdo`=1,1,0,1; `done` at E+5.
- Back-to-back: 4'b1100 then 4'b0011, with `load_valid` held → second handshake at the edge closing cycle E+5. The bit stream is 1,1,0,0 then 0,0,1,1 with exactly one idle (`sdo_valid`=0) cycle between the words.
- `load_valid` pulsed with `din`=4'hF during SHIFT → `load_ready`=0, word not accepted, frame output unchanged.
- `rst`=1 at the edge ending cycle E+2 → next cycle `sdo`=0, `sdo_valid`=0, `busy`=0, no `done`; a new load afterwards serializes correctly.
- `PISO_SERIALIZER_PARITY_EN` defined, `din`=4'b1011 → `sdo`=1,0,1,1,1 (parity 1) in E+1..E+5; `done` at E+6. With `din`=4'b1001, the parity bit is 0.
